// File: rtl/cv32e40p_apu_core_pkg.sv
// cv32e40p_apu_core_pkg: APU interface widths, the buffered request record and FIFO controller states.
package cv32e40p_apu_core_pkg;

    localparam int APU_NARGS_CPU    = 3;
    localparam int APU_WOP_CPU      = 6;
    localparam int APU_NDSFLAGS_CPU = 15;
    localparam int APU_NUSFLAGS_CPU = 5;

    typedef struct packed {
        logic [APU_NARGS_CPU-1:0][31:0] operands;
        logic [APU_WOP_CPU-1:0]         op;
        logic [APU_NDSFLAGS_CPU-1:0]    flags;
    } apu_req_t;

    typedef enum logic [1:0] {FIFO_EMPTY, FIFO_HOLD, FIFO_FULL} fifo_state_e;

endpackage

// File: rtl/cv32e40p_apu_req_fifo.sv
// cv32e40p_apu_req_fifo: DEPTH-entry in-order FIFO of APU requests; DEPTH need not be a power of two.
module cv32e40p_apu_req_fifo
    import cv32e40p_apu_core_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     i_push,
    input  apu_req_t i_data,
    input  logic     i_pop,
    output apu_req_t o_data,
    output logic     o_full,
    output logic     o_empty
);

    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    apu_req_t      r_mem [DEPTH];
    logic [PW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    fifo_state_e   r_state, w_state_nxt;
    logic          w_push, w_pop;

    // Push while full is only taken if the head leaves in the same cycle.
    assign w_push    = i_push && (r_state != FIFO_FULL || i_pop);
    assign w_pop     = i_pop && r_state != FIFO_EMPTY;
    assign w_cnt_nxt = r_cnt + CW'(w_push) - CW'(w_pop);

    always_comb
        w_state_nxt = (w_cnt_nxt == '0) ? FIFO_EMPTY : (w_cnt_nxt == FULL_CNT) ? FIFO_FULL : FIFO_HOLD;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_cnt   <= '0;
            r_state <= FIFO_EMPTY;
        end else begin
            r_wptr  <= w_push ? ((r_wptr == LAST) ? '0 : r_wptr + 1'b1) : r_wptr;
            r_rptr  <= w_pop ? ((r_rptr == LAST) ? '0 : r_rptr + 1'b1) : r_rptr;
            r_cnt   <= w_cnt_nxt;
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

    assign o_data  = r_mem[r_rptr];
    assign o_full  = r_state == FIFO_FULL;
    assign o_empty = r_state == FIFO_EMPTY;

    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(i_push && o_full));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i) !(i_pop && o_empty));

endmodule

// File: rtl/cv32e40p_apu_req_buffer.sv
// cv32e40p_apu_req_buffer: buffers core APU requests toward the FPU, throttles on in-flight count,
// and forwards results straight back to the core.
module cv32e40p_apu_req_buffer
    import cv32e40p_apu_core_pkg::*;
#(
    parameter int DEPTH           = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               core_req_i,
    output logic                               core_gnt_o,
    input  logic [APU_NARGS_CPU-1:0][31:0]     core_operands_i,
    input  logic [APU_WOP_CPU-1:0]             core_op_i,
    input  logic [APU_NDSFLAGS_CPU-1:0]        core_flags_i,
    output logic                               core_rvalid_o,
    output logic [31:0]                        core_result_o,
    output logic [APU_NUSFLAGS_CPU-1:0]        core_rflags_o,
    output logic                               fpu_req_o,
    input  logic                               fpu_gnt_i,
    output logic [APU_NARGS_CPU-1:0][31:0]     fpu_operands_o,
    output logic [APU_WOP_CPU-1:0]             fpu_op_o,
    output logic [APU_NDSFLAGS_CPU-1:0]        fpu_flags_o,
    input  logic                               fpu_rvalid_i,
    input  logic [31:0]                        fpu_rdata_i,
    input  logic [APU_NUSFLAGS_CPU-1:0]        fpu_rflags_i,
    output logic                               busy_o,
    output logic                               err_o
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    if (MAX_OUTSTANDING < DEPTH) begin : g_bad_cfg
        $error("MAX_OUTSTANDING must be >= DEPTH");
    end

    apu_req_t      w_req, w_head;
    logic          w_full, w_empty, w_push, w_pop;
    logic [CW-1:0] r_out_cnt;
    logic          r_err;

    assign w_req = '{operands: core_operands_i, op: core_op_i, flags: core_flags_i};

    // Grant uses only registered state, keeping fpu_gnt_i out of the core_gnt_o cone.
    assign core_gnt_o = !w_full && (r_out_cnt < CW'(MAX_OUTSTANDING));
    assign w_push     = core_req_i && core_gnt_o;
    assign fpu_req_o  = !w_empty;
    assign w_pop      = fpu_req_o && fpu_gnt_i;

    cv32e40p_apu_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_push),
        .i_data  (w_req),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign fpu_operands_o = w_head.operands;
    assign fpu_op_o       = w_head.op;
    assign fpu_flags_o    = w_head.flags;

    // A result with nothing in flight is a protocol error; the counter holds at zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            r_out_cnt <= (w_push && !fpu_rvalid_i) ? r_out_cnt + 1'b1 :
                         (!w_push && fpu_rvalid_i && r_out_cnt != '0) ? r_out_cnt - 1'b1 : r_out_cnt;
            r_err     <= r_err || (fpu_rvalid_i && r_out_cnt == '0);
        end
    end

    assign busy_o        = r_out_cnt != '0;
    assign err_o         = r_err;
    assign core_rvalid_o = fpu_rvalid_i;
    assign core_result_o = fpu_rdata_i;
    assign core_rflags_o = fpu_rflags_i;

    a_head_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        fpu_req_o && !fpu_gnt_i |=> fpu_req_o && $stable(w_head));

endmodule

// File: tb/tb_cv32e40p_apu_req_buffer.sv
// tb_cv32e40p_apu_req_buffer: directed plus random stimulus against a queue-based model of the buffer.
module tb_cv32e40p_apu_req_buffer;
    import cv32e40p_apu_core_pkg::*;

    localparam int DEPTH = 2;
    localparam int MAXO  = 4;

    logic                           clk = 1'b0, rst = 1'b1;
    logic                           core_req = 1'b0, core_gnt;
    logic [APU_NARGS_CPU-1:0][31:0] core_operands = '0;
    logic [APU_WOP_CPU-1:0]         core_op = '0;
    logic [APU_NDSFLAGS_CPU-1:0]    core_flags = '0;
    logic                           core_rvalid;
    logic [31:0]                    core_result;
    logic [APU_NUSFLAGS_CPU-1:0]    core_rflags;
    logic                           fpu_req, fpu_gnt = 1'b0;
    logic [APU_NARGS_CPU-1:0][31:0] fpu_operands;
    logic [APU_WOP_CPU-1:0]         fpu_op;
    logic [APU_NDSFLAGS_CPU-1:0]    fpu_flags;
    logic                           fpu_rvalid = 1'b0;
    logic [31:0]                    fpu_rdata = '0;
    logic [APU_NUSFLAGS_CPU-1:0]    fpu_rflags = '0;
    logic                           busy, err;

    always #5 clk = ~clk;

    cv32e40p_apu_req_buffer #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk), .rst_i(rst),
        .core_req_i(core_req), .core_gnt_o(core_gnt),
        .core_operands_i(core_operands), .core_op_i(core_op), .core_flags_i(core_flags),
        .core_rvalid_o(core_rvalid), .core_result_o(core_result), .core_rflags_o(core_rflags),
        .fpu_req_o(fpu_req), .fpu_gnt_i(fpu_gnt),
        .fpu_operands_o(fpu_operands), .fpu_op_o(fpu_op), .fpu_flags_o(fpu_flags),
        .fpu_rvalid_i(fpu_rvalid), .fpu_rdata_i(fpu_rdata), .fpu_rflags_i(fpu_rflags),
        .busy_o(busy), .err_o(err)
    );

    int       checks = 0, errors = 0;
    apu_req_t mq[$];
    int       mout = 0;
    bit       merr = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic apu_req_t cur();
        return '{operands: core_operands, op: core_op, flags: core_flags};
    endfunction

    task automatic drive(input bit req, input bit g, input bit rv);
        core_req      = req;
        fpu_gnt       = g;
        fpu_rvalid    = rv;
        core_operands = {$urandom, $urandom, $urandom};
        core_op       = APU_WOP_CPU'($urandom);
        core_flags    = APU_NDSFLAGS_CPU'($urandom);
        fpu_rdata     = $urandom;
        fpu_rflags    = APU_NUSFLAGS_CPU'($urandom);
    endtask

    // Compare every observable output with what the model predicts for this cycle.
    task automatic settle();
        #2;
        chk("gnt", 128'(core_gnt), 128'(mq.size() < DEPTH && mout < MAXO));
        chk("fpu_req", 128'(fpu_req), 128'(mq.size() != 0));
        chk("busy", 128'(busy), 128'(mout != 0));
        chk("err", 128'(err), 128'(merr));
        if (mq.size() != 0) chk("head", 128'({fpu_operands, fpu_op, fpu_flags}), 128'(mq[0]));
        chk("rvalid", 128'(core_rvalid), 128'(fpu_rvalid));
        if (fpu_rvalid) chk("result", 128'({core_result, core_rflags}), 128'({fpu_rdata, fpu_rflags}));
    endtask

    task automatic tick();
        bit push, pop;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            mout = 0;
            merr = 1'b0;
        end else begin
            push = core_req && mq.size() < DEPTH && mout < MAXO;
            pop  = mq.size() != 0 && fpu_gnt;
            if (fpu_rvalid && mout == 0) merr = 1'b1;
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(cur());
            if (push && !fpu_rvalid) mout++;
            else if (!push && fpu_rvalid && mout > 0) mout--;
        end
        #1;
    endtask

    task automatic cyc();
        settle();
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0);
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && (mout > 0 || mq.size() > 0); n++) begin
            drive(0, 1, mout > 0);
            cyc();
        end
        chk("drained", 128'(busy), 128'(0));
    endtask

    initial begin
        apu_req_t a, b;
        int n;
        do_reset();
        drive(0, 0, 0);
        settle();
        chk("rst_gnt", 128'(core_gnt), 128'(1));
        chk("rst_req", 128'(fpu_req), 128'(0));
        tick();

        // Single op with the FPU always granting.
        drive(1, 1, 0); settle(); chk("t1_acc", 128'(core_gnt), 128'(1)); a = cur(); tick();
        drive(0, 1, 0); settle();
        chk("t1_req_c1", 128'(fpu_req), 128'(1));
        chk("t1_data_c1", 128'({fpu_operands, fpu_op, fpu_flags}), 128'(a));
        chk("t1_busy_c1", 128'(busy), 128'(1));
        tick();
        drive(0, 1, 0); settle(); chk("t1_busy_c2", 128'(busy), 128'(1)); tick();
        drive(0, 1, 1); settle();
        chk("t1_rvalid_c3", 128'(core_rvalid), 128'(1));
        chk("t1_busy_c3", 128'(busy), 128'(1));
        tick();
        drive(0, 1, 0); settle(); chk("t1_busy_c4", 128'(busy), 128'(0)); tick();

        // Fill to DEPTH with the FPU stalled, then release in order.
        drive(1, 0, 0); settle(); chk("t2_gnt_a", 128'(core_gnt), 128'(1)); a = cur(); tick();
        drive(1, 0, 0); settle(); chk("t2_gnt_b", 128'(core_gnt), 128'(1)); b = cur(); tick();
        drive(1, 0, 0); settle(); chk("t2_full", 128'(core_gnt), 128'(0)); tick();
        drive(1, 0, 0); settle(); chk("t2_hold", 128'({fpu_operands, fpu_op, fpu_flags}), 128'(a)); tick();
        drive(1, 1, 0); settle();
        chk("t2_pop_a", 128'({fpu_operands, fpu_op, fpu_flags}), 128'(a));
        chk("t2_nogrant_full", 128'(core_gnt), 128'(0));
        tick();
        drive(1, 1, 0); settle();
        chk("t2_pop_b", 128'({fpu_operands, fpu_op, fpu_flags}), 128'(b));
        chk("t2_regrant", 128'(core_gnt), 128'(1));
        tick();
        drain();

        // Outstanding limit with no results returning.
        n = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 0); settle(); n += int'(core_gnt); tick();
        end
        chk("t3_accepts", 128'(n), 128'(MAXO));
        drive(1, 1, 1); settle(); chk("t3_limit", 128'(core_gnt), 128'(0)); tick();
        n = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 0); settle(); n += int'(core_gnt); tick();
        end
        chk("t3_one_more", 128'(n), 128'(1));
        drain();

        // Push, pop and result together every cycle; pointers wrap many times.
        drive(1, 0, 0); cyc();
        n = 0;
        for (int i = 0; i < 100; i++) begin
            drive(1, 1, 1); settle(); n += int'(core_gnt && fpu_req && busy); tick();
        end
        chk("t4_steady", 128'(n), 128'(100));
        drain();

        // Random traffic; results only while something is in flight.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), mout > 0 && $urandom_range(0, 2) == 0);
            cyc();
        end
        drain();

        // Reset with two buffered entries and one op inside the FPU.
        drive(1, 0, 0); cyc();
        drive(1, 0, 0); cyc();
        drive(0, 1, 0); cyc();
        drive(1, 0, 0); cyc();
        chk("t6_setup", 128'({fpu_req, busy, core_gnt}), 128'(3'b110));
        do_reset();
        drive(0, 0, 0); settle();
        chk("t6_req", 128'(fpu_req), 128'(0));
        chk("t6_busy", 128'(busy), 128'(0));
        chk("t6_gnt", 128'(core_gnt), 128'(1));
        tick();

        // Stray result sets a sticky error until reset.
        drive(0, 0, 1); settle();
        chk("t5_err_pre", 128'(err), 128'(0));
        chk("t5_fwd", 128'(core_rvalid), 128'(1));
        tick();
        drive(0, 0, 0); settle(); chk("t5_err_set", 128'(err), 128'(1)); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0); cyc();
        end
        chk("t5_err_held", 128'(err), 128'(1));
        do_reset();
        drive(0, 0, 0); settle(); chk("t5_err_clr", 128'(err), 128'(0)); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
